fp_mul_sequencer: RTL and testbench
===================================

Name: fp_mul_sequencer

Overview:
Upstream operand dispatcher for the 32-bit floating-point multiplier. Accepts IEEE-754 single-precision operand pairs on a valid/ready stream and buffers them in a small FIFO. Issues one pair at a time to the multiplier with a start pulse and waits for its done. Captures the product and exception flags into a result register presented on a valid/ready output stream, with a watchdog timeout and a completed-operation counter.

Parameters:
DEPTH, 4, operand FIFO entries; power of two, ≥2
TIMEOUT_CYCLES, 64, max cycles in WAIT before the operation is abandoned; ≥2
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
op_valid_i  in  1  operand pair valid
op_ready_o  out  1  FIFO can accept a pair (= not full)
op_a_i  in  32  operand A, IEEE-754 single
op_b_i  in  32  operand B, IEEE-754 single
mul_a_o  out  32  operand A to multiplier (registered)
mul_b_o  out  32  operand B to multiplier (registered)
mul_start_o  out  1  one-cycle start pulse to multiplier
mul_done_i  in  1  multiplier done
mul_product_i  in  32  multiplier product
mul_flags_i  in  4  {nan, infinite, overflow, underflow} from multiplier
res_valid_o  out  1  result register holds an unconsumed result
res_ready_i  in  1  downstream accepts result
res_product_o  out  32  captured product
res_flags_o  out  4  captured flags, same order as mul_flags_i
timeout_o  out  1  sticky: an operation timed out
ops_done_o  out  CNT_W  count of results delivered (wraps)
busy_o  out  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (rst high at an edge): FIFO emptied, FSM→IDLE, all outputs 0 except op_ready_o=1 in the cycle after reset. Reset mid-operation abandons the operation; no result, no start.
- Push: on edge with op_valid_i & op_ready_o. op_ready_o = (count != DEPTH), combinational from count. When full, ready=0 and the pair is not taken; a pop in the same cycle does not make ready high until the next cycle.
- FIFO: circular, log2(DEPTH)-bit pointers wrap; count is log2(DEPTH)+1 bits. Simultaneous push and pop: count unchanged, both pointers advance.
- FSM states IDLE, ISSUE, WAIT, OUT:
  - IDLE: if FIFO non-empty, pop head into mul_a_o/mul_b_o → ISSUE.
  - ISSUE: mul_start_o=1 for this single cycle; clear the wait counter → WAIT.
  - WAIT: mul_done_i=1 → latch mul_product_i/mul_flags_i into res_*; res_valid_o=1 → OUT. Otherwise increment the counter; on the cycle where counter == TIMEOUT_CYCLES-1 with no done, set timeout_o, discard the operation, → IDLE.
  - OUT: hold res_* stable while res_valid_o & !res_ready_i. On handshake: res_valid_o=0, ops_done_o+1 (wraps), → IDLE.
- mul_a_o/mul_b_o are held stable from ISSUE until the next pop.
- mul_done_i is ignored in IDLE, ISSUE and OUT; only the first done cycle in WAIT counts.
- Latency: a pair pushed at edge N into an empty FIFO with the FSM in IDLE gives mul_start_o high in the cycle after edge N+2. A result is visible on res_* the cycle after the done edge.
- timeout_o clears only on rst.
- busy_o = (state != IDLE) | (count != 0).

Test Plan:
- Single op: push A=0x40000000 (2.0), B=0x40400000 (3.0); model multiplier returns done after 5 cycles with 0x40C00000 → mul_start_o exactly 1 cycle, res_product_o=0x40C00000, res_flags_o=0, ops_done_o=1 after res_ready_i.
- Fill/backpressure: hold the multiplier done low, push 6 pairs with DEPTH=4 → 1 pair issued, 4 buffered, op_ready_o=0 on 5th buffered attempt; release → all 5 complete in push order.
- Result stall: res_ready_i=0 for 10 cycles after a result → res_* stable, no new mul_start_o; raise ready → next pair issued.
- NaN flags: A=0x7FC00000, B=0x3F800000; model returns 0x7FC00000, flags 4'b1000 → res_flags_o=4'b1000.
- Timeout: model never asserts done → timeout_o=1 at cycle TIMEOUT_CYCLES after start, FSM returns to IDLE, next queued pair issues, no result for the dropped pair.
- Reset in WAIT: assert rst while waiting → all outputs 0, FIFO empty, a late mul_done_i is ignored, ops_done_o=0.

Source files
------------

// File: rtl/fp_mul_sequencer_if.sv
// Signal bundle between the operand dispatcher and its environment:
// operand stream in, multiplier issue/return bus, result stream out, status.
interface fp_mul_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             op_valid_i;
  logic             op_ready_o;
  logic [31:0]      op_a_i;
  logic [31:0]      op_b_i;
  logic [31:0]      mul_a_o;
  logic [31:0]      mul_b_o;
  logic             mul_start_o;
  logic             mul_done_i;
  logic [31:0]      mul_product_i;
  logic [3:0]       mul_flags_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [31:0]      res_product_o;
  logic [3:0]       res_flags_o;
  logic             timeout_o;
  logic [CNT_W-1:0] ops_done_o;
  logic             busy_o;

  // Sequencer side
  modport master (
    input  op_valid_i, op_a_i, op_b_i, mul_done_i, mul_product_i, mul_flags_i,
           res_ready_i,
    output op_ready_o, mul_a_o, mul_b_o, mul_start_o, res_valid_o,
           res_product_o, res_flags_o, timeout_o, ops_done_o, busy_o
  );

  // Environment side: operand source, multiplier and result sink
  modport slave (
    output op_valid_i, op_a_i, op_b_i, mul_done_i, mul_product_i, mul_flags_i,
           res_ready_i,
    input  op_ready_o, mul_a_o, mul_b_o, mul_start_o, res_valid_o,
           res_product_o, res_flags_o, timeout_o, ops_done_o, busy_o
  );
endinterface

// File: rtl/fp_mul_sequencer.sv
// Operand dispatcher for the single-precision multiplier: buffers operand
// pairs in a circular FIFO, issues one pair at a time with a start pulse,
// waits (with watchdog) for done and presents the product on a result stream.
module fp_mul_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input logic               clk,
  input logic               rst,
  fp_mul_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [PTR_W:0]  FULL      = (PTR_W+1)'(DEPTH);
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fifo_a_q [DEPTH];
  logic [31:0]      fifo_b_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [31:0]      mul_a_q, mul_b_q;
  logic             start_q;
  logic [TO_W-1:0]  wait_q;
  logic [31:0]      res_product_q;
  logic [3:0]       res_flags_q;
  logic             res_valid_q;
  logic             timeout_q;
  logic [CNT_W-1:0] ops_done_q;
  logic             push, pop, done_hit, timeout_hit, res_hs;

  assign push        = bus.op_valid_i & (count_q != FULL);
  assign pop         = (state_q == IDLE) & (count_q != '0);
  // Only a done seen while waiting counts; it takes priority over the watchdog.
  assign done_hit    = (state_q == WAIT) & bus.mul_done_i;
  assign timeout_hit = (state_q == WAIT) & ~bus.mul_done_i & (wait_q == WAIT_LAST);
  assign res_hs      = (state_q == OUT) & res_valid_q & bus.res_ready_i;

  // Operand storage, written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= bus.op_a_i;
      fifo_b_q[wr_ptr_q] <= bus.op_b_i;
    end
  end

  // FIFO pointers (wrap naturally, DEPTH is a power of two) and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_hit) state_d = OUT;
               else if (timeout_hit) state_d = IDLE;
      OUT:     if (res_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue operands, start pulse, watchdog, result capture and status counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      start_q       <= 1'b0;
      wait_q        <= '0;
      res_product_q <= '0;
      res_flags_q   <= '0;
      res_valid_q   <= 1'b0;
      timeout_q     <= 1'b0;
      ops_done_q    <= '0;
    end else begin
      // Start is registered so it rises together with entry into WAIT.
      start_q <= (state_q == ISSUE);
      if (pop) begin
        mul_a_q <= fifo_a_q[rd_ptr_q];
        mul_b_q <= fifo_b_q[rd_ptr_q];
      end
      if (state_q == ISSUE) begin
        wait_q <= '0;
      end else if ((state_q == WAIT) && !bus.mul_done_i && (wait_q != WAIT_LAST)) begin
        wait_q <= wait_q + 1'b1;
      end
      if (done_hit) begin
        res_product_q <= bus.mul_product_i;
        res_flags_q   <= bus.mul_flags_i;
        res_valid_q   <= 1'b1;
      end else if (res_hs) begin
        res_valid_q   <= 1'b0;
      end
      if (timeout_hit) timeout_q <= 1'b1;
      if (res_hs) ops_done_q <= ops_done_q + 1'b1;
    end
  end

  assign bus.op_ready_o    = (count_q != FULL);
  assign bus.mul_a_o       = mul_a_q;
  assign bus.mul_b_o       = mul_b_q;
  assign bus.mul_start_o   = start_q;
  assign bus.res_valid_o   = res_valid_q;
  assign bus.res_product_o = res_product_q;
  assign bus.res_flags_o   = res_flags_q;
  assign bus.timeout_o     = timeout_q;
  assign bus.ops_done_o    = ops_done_q;
  assign bus.busy_o        = (state_q != IDLE) | (count_q != '0);
endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Self-checking bench for fp_mul_sequencer: table-driven single operations,
// hand-written corner sequences and a randomized run against a queue model.
module tb_fp_mul_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 64;
  localparam int CW    = 16;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] prod;
    logic [3:0]  flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_sequencer_if #(.CNT_W(CW)) bus ();
  fp_mul_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  vec_t        tbl [6];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] pa_q [$];
  logic [31:0] pb_q [$];
  logic [35:0] exp_q [$];
  int          ops_model = 0;
  int          starts = 0;
  int          lat_cfg = 1;
  bit          hold_done = 0;
  bit          never = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Stand-in multiplier: known products for the table, a scramble otherwise.
  function automatic logic [35:0] env_mul(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 6; i++)
      if (tbl[i].a == a && tbl[i].b == b) return {tbl[i].flags, tbl[i].prod};
    return {a[3:0] ^ b[7:4], a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F};
  endfunction

  function automatic bit sig(input int which);
    case (which)
      0:       return bus.mul_start_o;
      1:       return bus.res_valid_o;
      default: return bus.timeout_o;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string nm, output int n);
    n = 0;
    while (!sig(which)) begin
      tick();
      n++;
      if (n > 400) begin
        vectors++;
        errors++;
        $display("FAIL %s: got no event within 400 cycles, want one", nm);
        return;
      end
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, output bit ok);
    bus.op_valid_i = 1'b1;
    bus.op_a_i     = a;
    bus.op_b_i     = b;
    ok = bus.op_ready_o;
    if (ok) begin
      pa_q.push_back(a);
      pb_q.push_back(b);
    end
    tick();
    bus.op_valid_i = 1'b0;
    bus.op_a_i     = $urandom;
    bus.op_b_i     = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.op_valid_i  = 1'b0;
    bus.res_ready_i = 1'b0;
    tick();
    tick();
    pa_q.delete();
    pb_q.delete();
    exp_q.delete();
    ops_model = 0;
    rst = 1'b0;
  endtask

  // Multiplier responder: done after lat_cfg cycles (random 1..6 when 0)
  initial begin : responder
    int          cnt;
    bit          pend;
    logic [35:0] r;
    pend = 0;
    cnt  = 0;
    r    = '0;
    bus.mul_done_i = 1'b0;
    bus.mul_product_i = '0;
    bus.mul_flags_i = '0;
    forever begin
      @(negedge clk);
      bus.mul_done_i    = 1'b0;
      bus.mul_product_i = $urandom;
      bus.mul_flags_i   = 4'($urandom);
      if (bus.mul_start_o === 1'b1 && !rst) begin
        pend = !never;
        cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 6)) : lat_cfg;
        r    = env_mul(bus.mul_a_o, bus.mul_b_o);
      end else if (pend) begin
        if (cnt > 1) cnt--;
        else if (!hold_done) begin
          bus.mul_done_i = 1'b1;
          {bus.mul_flags_i, bus.mul_product_i} = r;
          pend = 0;
        end
      end
    end
  end

  // Reference model: issue order, result order, result hold and op count
  initial begin : monitor
    bit          prev_start, prev_hold;
    logic [35:0] prev_res;
    prev_start = 0;
    prev_hold  = 0;
    prev_res   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 0;
        prev_hold  = 0;
      end else begin
        if (bus.mul_start_o) begin
          starts++;
          chk("start_single_cycle", 64'(prev_start), 0);
          if (pa_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_start: got a=0x%0h b=0x%0h, want no issue", bus.mul_a_o, bus.mul_b_o);
          end else begin
            chk("issue_operands", {bus.mul_a_o, bus.mul_b_o}, {pa_q[0], pb_q[0]});
            if (!never) exp_q.push_back(env_mul(pa_q[0], pb_q[0]));
            void'(pa_q.pop_front());
            void'(pb_q.pop_front());
          end
        end
        if (prev_hold)
          chk("result_held", {bus.res_valid_o, bus.res_flags_o, bus.res_product_o}, {1'b1, prev_res});
        if (bus.res_valid_o && bus.res_ready_i) begin
          ops_model++;
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_result: got 0x%0h, want none", bus.res_product_o);
          end else begin
            chk("result_order", {bus.res_flags_o, bus.res_product_o}, exp_q.pop_front());
          end
        end
        prev_start = bus.mul_start_o;
        prev_hold  = bus.res_valid_o & !bus.res_ready_i;
        prev_res   = {bus.res_flags_o, bus.res_product_o};
      end
    end
  end

  initial begin : main
    bit             ok;
    int             n, nt, st, pushes, guard;
    logic [CW-1:0]  ob;
    logic [35:0]    snap;
    logic [31:0]    ya, yb;

    tbl[0] = '{"mul_2x3",   32'h4000_0000, 32'h4040_0000, 5, 32'h40C0_0000, 4'b0000};
    tbl[1] = '{"nan_x1",    32'h7FC0_0000, 32'h3F80_0000, 3, 32'h7FC0_0000, 4'b1000};
    tbl[2] = '{"one_x_one", 32'h3F80_0000, 32'h3F80_0000, 1, 32'h3F80_0000, 4'b0000};
    tbl[3] = '{"inf_x2",    32'h7F80_0000, 32'h4000_0000, 2, 32'h7F80_0000, 4'b0100};
    tbl[4] = '{"overflow",  32'h7F00_0000, 32'h7F00_0000, 4, 32'h7F80_0000, 4'b0110};
    tbl[5] = '{"underflow", 32'h0080_0000, 32'h0080_0000, 2, 32'h0000_0000, 4'b0001};

    rst = 1'b1;
    bus.op_valid_i  = 1'b0;
    bus.op_a_i      = '0;
    bus.op_b_i      = '0;
    bus.res_ready_i = 1'b0;
    do_reset();
    chk("rst_op_ready",  bus.op_ready_o, 1);
    chk("rst_start",     bus.mul_start_o, 0);
    chk("rst_res_valid", bus.res_valid_o, 0);
    chk("rst_timeout",   bus.timeout_o, 0);
    chk("rst_ops_done",  bus.ops_done_o, 0);
    chk("rst_busy",      bus.busy_o, 0);
    chk("rst_mul_ops",   {bus.mul_a_o, bus.mul_b_o}, 0);
    chk("rst_res",       {bus.res_flags_o, bus.res_product_o}, 0);

    // Table-driven single operations
    for (int i = 0; i < 6; i++) begin
      lat_cfg = tbl[i].lat;
      push(tbl[i].a, tbl[i].b, ok);
      chk({tbl[i].name, "_accept"}, 64'(ok), 1);
      wait_sig(0, {tbl[i].name, "_start"}, n);
      chk({tbl[i].name, "_start_latency"}, n + 1, 3);
      tick();
      chk({tbl[i].name, "_start_low"}, bus.mul_start_o, 0);
      wait_sig(1, {tbl[i].name, "_result"}, n);
      chk({tbl[i].name, "_result_latency"}, n, tbl[i].lat);
      chk({tbl[i].name, "_product"}, bus.res_product_o, tbl[i].prod);
      chk({tbl[i].name, "_flags"}, bus.res_flags_o, tbl[i].flags);
      ob = bus.ops_done_o;
      bus.res_ready_i = 1'b1;
      tick();
      bus.res_ready_i = 1'b0;
      chk({tbl[i].name, "_ops_done"}, bus.ops_done_o, ob + 1'b1);
      chk({tbl[i].name, "_res_cleared"}, bus.res_valid_o, 0);
    end

    // Fill and backpressure with the multiplier stalled
    lat_cfg   = 2;
    hold_done = 1;
    ob = bus.ops_done_o;
    push(32'h4100_0000, 32'h4110_0000, ok);
    wait_sig(0, "fill_first_start", n);
    tick();
    for (int k = 1; k <= 4; k++) begin
      push(32'h4100_0000 + (k << 16), 32'h4110_0000 + (k << 16), ok);
      chk("fill_accept", 64'(ok), 1);
    end
    chk("full_ready_low", bus.op_ready_o, 0);
    chk("full_busy", bus.busy_o, 1);
    push(32'hDEAD_0006, 32'hBEEF_0006, ok);
    chk("full_reject", 64'(ok), 0);
    chk("full_ready_still_low", bus.op_ready_o, 0);
    hold_done = 0;
    bus.res_ready_i = 1'b1;
    guard = 0;
    while (bus.ops_done_o != ob + CW'(5) && guard < 300) begin
      tick();
      guard++;
    end
    bus.res_ready_i = 1'b0;
    chk("fill_drain_count", bus.ops_done_o, ob + CW'(5));
    repeat (4) tick();
    chk("fill_no_extra_issue", pa_q.size() + exp_q.size(), 0);
    chk("fill_idle_busy", bus.busy_o, 0);
    chk("fill_ready_back", bus.op_ready_o, 1);

    // Result stall: result held, nothing issued until it is consumed
    lat_cfg = 2;
    push(32'h3FC0_0000, 32'h4020_0000, ok);
    push(32'h4060_0000, 32'h4080_0000, ok);
    wait_sig(1, "stall_result", n);
    snap = {bus.res_flags_o, bus.res_product_o};
    st = starts;
    repeat (10) begin
      tick();
      chk("stall_res", {bus.res_valid_o, bus.res_flags_o, bus.res_product_o}, {1'b1, snap});
    end
    chk("stall_no_start", starts, st);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    wait_sig(0, "stall_next_start", n);
    chk("stall_next_issue_latency", n, 2);
    wait_sig(1, "stall_second_result", n);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;

    // Watchdog: first operation never completes, second one still runs
    never = 1;
    ob = bus.ops_done_o;
    push(32'h4140_0000, 32'h4150_0000, ok);
    ya = 32'h4160_0000;
    yb = 32'h4170_0000;
    push(ya, yb, ok);
    wait_sig(0, "timeout_start", n);
    tick();
    never = 0;
    chk("timeout_not_yet", bus.timeout_o, 0);
    wait_sig(2, "timeout_flag", nt);
    chk("timeout_cycles", nt + 1, TO);
    wait_sig(0, "timeout_next_start", n);
    chk("timeout_next_issue_latency", n, 2);
    chk("timeout_next_operands", {bus.mul_a_o, bus.mul_b_o}, {ya, yb});
    wait_sig(1, "timeout_next_result", n);
    chk("timeout_next_product", {bus.res_flags_o, bus.res_product_o}, env_mul(ya, yb));
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    chk("timeout_one_result", bus.ops_done_o, ob + 1'b1);
    chk("timeout_sticky", bus.timeout_o, 1);

    // Reset while waiting: everything cleared, the late done is ignored
    lat_cfg = 8;
    push(32'h4180_0000, 32'h4190_0000, ok);
    wait_sig(0, "rstwait_start", n);
    tick();
    tick();
    st = starts;
    do_reset();
    chk("rstwait_timeout", bus.timeout_o, 0);
    chk("rstwait_ops_done", bus.ops_done_o, 0);
    chk("rstwait_busy", bus.busy_o, 0);
    chk("rstwait_ready", bus.op_ready_o, 1);
    chk("rstwait_outputs", {bus.mul_a_o, bus.mul_b_o, bus.mul_start_o, bus.res_valid_o}, 0);
    repeat (12) tick();
    chk("rstwait_late_done_res", {bus.res_valid_o, bus.res_flags_o, bus.res_product_o}, 0);
    chk("rstwait_no_start", starts, st);
    chk("rstwait_ops_after", bus.ops_done_o, 0);

    // Randomized traffic with random multiplier latency and sink backpressure
    lat_cfg = 0;
    pushes  = 0;
    guard   = 0;
    while (pushes < 40 && guard < 3000) begin
      bus.res_ready_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        push($urandom, $urandom, ok);
        if (ok) pushes++;
      end else begin
        tick();
      end
      guard++;
    end
    bus.res_ready_i = 1'b1;
    guard = 0;
    while ((bus.busy_o || bus.res_valid_o) && guard < 600) begin
      tick();
      guard++;
    end
    bus.res_ready_i = 1'b0;
    chk("rand_pushes", pushes, 40);
    chk("rand_ops_total", bus.ops_done_o, 40);
    chk("rand_ops_model", bus.ops_done_o, CW'(ops_model));
    chk("rand_queues_empty", pa_q.size() + exp_q.size(), 0);
    chk("rand_no_timeout", bus.timeout_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
